// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage in front of decode.
//
// Owns the 12-bit program counter and issues one-cycle-latency reads to the
// instruction ROM. Each returned word is paired with its fetch address and
// pushed into a small in-order queue. The queue head is presented to decode.
// A branch redirect flushes all younger work: the queue, any due response,
// and the fetch that would otherwise issue that cycle.
//
// Optional feature macro: FETCH_BANK_REGS_EN
//   defined   -> FB/EB bank registers written via fb_we/eb_we/bank_wdata
//   undefined -> bits_FB/bits_EB tied to 0, bank write inputs ignored
//
// Parameters:
//   RESET_PC  PC loaded at reset (default 12'o4000)
//   QDEPTH    queue entries including the head (>= 2)
//
// Ports:
//   clock        in   single rising-edge clock
//   rst          in   asynchronous active-high reset
//   stall        in   decode cannot accept the head this cycle
//   redirect     in   branch taken, load redirect_pc
//   redirect_pc  in   branch target
//   halt         in   stop issuing fetches (sticky until rst)
//   rom_en       out  ROM read request
//   rom_addr     out  ROM read address
//   rom_data     in   ROM word, valid the cycle after rom_en
//   instr, pc    out  queue-head instruction and its PC (0 when empty)
//   instr_valid  out  head is valid
//   flush        out  clear for decode's internal registers
//   fb_we, eb_we in   bank register write enables
//   bank_wdata   in   bank write data
//   bits_FB/EB   out  current bank registers
module fetch_queue #(
    parameter logic [11:0] RESET_PC = 12'o4000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [11:0] redirect_pc,
    input  logic        halt,
    output logic        rom_en,
    output logic [11:0] rom_addr,
    input  logic [14:0] rom_data,
    output logic [14:0] instr,
    output logic [11:0] pc,
    output logic        instr_valid,
    output logic        flush,
    input  logic        fb_we,
    input  logic        eb_we,
    input  logic [2:0]  bank_wdata,
    output logic [2:0]  bits_FB,
    output logic [2:0]  bits_EB
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    logic [11:0]   pc_q;
    logic          pending;
    logic [11:0]   pend_pc;
    logic [CW-1:0] count;
    logic          halted;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_ptr_next;
    logic [PW-1:0] tail_ptr;

    logic [14:0]   mem_instr [QDEPTH];
    logic [11:0]   mem_pc    [QDEPTH];

    logic          deq;
    logic          enq;
    logic [CW:0]   occupancy;

    // ---- Issue / dequeue decisions (combinational) ----
    assign instr_valid = (count != '0);
    assign deq         = instr_valid & ~stall;
    assign enq         = pending & ~redirect;
    assign flush       = redirect & ~rst;

    // Slots that will be committed after this cycle if nothing new is issued;
    // issuing only when this is below QDEPTH reserves room for every read in
    // flight, so the queue can never overflow.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, pending} - {{CW{1'b0}}, deq};

    assign rom_en   = ~rst & ~halted & ~redirect & (occupancy < (CW+1)'(QDEPTH));
    assign rom_addr = pc_q;

    always_comb begin
        int t;
        t = int'(rd_ptr) + int'(count);
        if (t >= QDEPTH)
            t = t - QDEPTH;
        tail_ptr = PW'(t);

        if (rd_ptr == PW'(QDEPTH - 1))
            rd_ptr_next = '0;
        else
            rd_ptr_next = rd_ptr + 1'b1;
    end

    // ---- Head output ----
    // The head slot is never the enqueue target while valid (count < QDEPTH
    // whenever a response is due), so instr/pc stay stable under stall.
    assign instr = instr_valid ? mem_instr[rd_ptr] : '0;
    assign pc    = instr_valid ? mem_pc[rd_ptr]    : '0;

    // ---- Control state ----
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            pending <= 1'b0;
            count   <= '0;
            rd_ptr  <= '0;
            halted  <= 1'b0;
        end else begin
            // rom_en is already forced low by redirect, so this also discards
            // a due response on redirect.
            pending <= rom_en;
            if (redirect) begin
                pc_q   <= redirect_pc;
                count  <= '0;
                rd_ptr <= '0;
            end else begin
                if (rom_en)
                    pc_q <= pc_q + 12'd1;
                if (deq)
                    rd_ptr <= rd_ptr_next;
                if (enq && !deq)
                    count <= count + 1'b1;
                else if (!enq && deq)
                    count <= count - 1'b1;
            end
            if (halt && !redirect)
                halted <= 1'b1;
        end
    end

    // ---- Data capture (no reset needed; qualified by control state) ----
    always_ff @(posedge clock) begin
        if (rom_en)
            pend_pc <= pc_q;
        if (enq) begin
            mem_instr[tail_ptr] <= rom_data;
            mem_pc[tail_ptr]    <= pend_pc;
        end
    end

    // ---- Bank registers ----
`ifdef FETCH_BANK_REGS_EN
    logic [2:0] fb_q;
    logic [2:0] eb_q;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            fb_q <= '0;
            eb_q <= '0;
        end else begin
            if (fb_we)
                fb_q <= bank_wdata;
            if (eb_we)
                eb_q <= bank_wdata;
        end
    end

    assign bits_FB = fb_q;
    assign bits_EB = eb_q;
`else
    logic bank_unused;
    assign bank_unused = ^{fb_we, eb_we, bank_wdata};
    assign bits_FB     = '0;
    assign bits_EB     = '0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: per-cycle expected outputs are computed from a
// queue-level reference model and pushed into a scoreboard; a monitor on the
// falling edge pops one record per cycle and compares it with the DUT.
module tb_fetch_queue;

    localparam int          QDEPTH   = 2;
    localparam logic [11:0] RESET_PC = 12'o4000;

    logic        clock;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [11:0] redirect_pc;
    logic        halt;
    logic        rom_en;
    logic [11:0] rom_addr;
    logic [14:0] rom_data;
    logic [14:0] instr;
    logic [11:0] pc;
    logic        instr_valid;
    logic        flush;
    logic        fb_we;
    logic        eb_we;
    logic [2:0]  bank_wdata;
    logic [2:0]  bits_FB;
    logic [2:0]  bits_EB;

    fetch_queue #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .clock(clock), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt(halt), .rom_en(rom_en),
        .rom_addr(rom_addr), .rom_data(rom_data), .instr(instr), .pc(pc),
        .instr_valid(instr_valid), .flush(flush), .fb_we(fb_we),
        .eb_we(eb_we), .bank_wdata(bank_wdata), .bits_FB(bits_FB),
        .bits_EB(bits_EB)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        en;
        logic [11:0] addr;
        logic        fl;
        logic        vld;
        logic [14:0] ins;
        logic [11:0] p;
        logic [2:0]  fb;
        logic [2:0]  eb;
    } exp_t;

    typedef struct {
        logic [14:0] ins;
        logic [11:0] p;
    } item_t;

    exp_t  exp_q[$];
    item_t mq[$];
    logic [11:0] m_pc;
    bit          m_pend;
    logic [11:0] m_pend_addr;
    bit          m_halted;
    logic [2:0]  m_fb;
    logic [2:0]  m_eb;

    int checks   = 0;
    int failures = 0;

    function automatic logic [14:0] rom_word(input logic [11:0] a);
        return {a[5:0], a[11:3]} ^ 15'h2B5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    // Monitor: one expected record per clock cycle.
    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rom_en",      32'(rom_en),      32'(e.en));
            chk("rom_addr",    32'(rom_addr),    32'(e.addr));
            chk("flush",       32'(flush),       32'(e.fl));
            chk("instr_valid", 32'(instr_valid), 32'(e.vld));
            chk("instr",       32'(instr),       32'(e.ins));
            chk("pc",          32'(pc),          32'(e.p));
            chk("bits_FB",     32'(bits_FB),     32'(e.fb));
            chk("bits_EB",     32'(bits_EB),     32'(e.eb));
        end
    end

    // Called just after a rising edge; drives one cycle and advances the model.
    task automatic cycle(input bit st, input bit rd, input logic [11:0] rpc,
                         input bit hl, input bit fbw, input bit ebw,
                         input logic [2:0] wd);
        exp_t  e;
        item_t it;
        bit    v, dq, en;
        int    occ;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        halt        = hl;
        fb_we       = fbw;
        eb_we       = ebw;
        bank_wdata  = wd;
        rom_data    = m_pend ? rom_word(m_pend_addr) : 15'($urandom);

        v   = (mq.size() != 0);
        dq  = v && !st;
        occ = mq.size() + int'(m_pend) - int'(dq);
        en  = !m_halted && !rd && (occ < QDEPTH);

        e.en   = en;
        e.addr = m_pc;
        e.fl   = rd;
        e.vld  = v;
        e.ins  = v ? mq[0].ins : 15'd0;
        e.p    = v ? mq[0].p   : 12'd0;
        e.fb   = m_fb;
        e.eb   = m_eb;
        exp_q.push_back(e);

        @(posedge clock);
        #1;

        if (rd) begin
            mq.delete();
            m_pend = 1'b0;
            m_pc   = rpc;
        end else begin
            if (dq)
                void'(mq.pop_front());
            if (m_pend) begin
                it.ins = rom_word(m_pend_addr);
                it.p   = m_pend_addr;
                mq.push_back(it);
            end
            m_pend      = en;
            m_pend_addr = m_pc;
            if (en)
                m_pc = m_pc + 12'd1;
        end
        if (hl && !rd)
            m_halted = 1'b1;
`ifdef FETCH_BANK_REGS_EN
        if (fbw) m_fb = wd;
        if (ebw) m_eb = wd;
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic do_reset(input int n);
        exp_t e;
        rst = 1'b1;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
        fb_we = 1'b0; eb_we = 1'b0; bank_wdata = '0; rom_data = '0;
        mq.delete();
        m_pc = RESET_PC; m_pend = 1'b0; m_pend_addr = '0; m_halted = 1'b0;
        m_fb = '0; m_eb = '0;
        for (int i = 0; i < n; i++) begin
            e.en = 1'b0; e.addr = RESET_PC; e.fl = 1'b0; e.vld = 1'b0;
            e.ins = '0; e.p = '0; e.fb = '0; e.eb = '0;
            exp_q.push_back(e);
            @(posedge clock);
            #1;
        end
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
        fb_we = 1'b0; eb_we = 1'b0; bank_wdata = '0; rom_data = '0;
        @(posedge clock);
        #1;

        // Reset values, then streaming from RESET_PC.
        do_reset(2);
        idle(10);

        // Stall fill for 5 cycles, then release.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0, 3'd0);
        idle(6);

        // Redirect while stalled with an entry held and a response due.
        cycle(1'b1, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0, 3'd0);
        cycle(1'b1, 1'b1, 12'o2345, 1'b0, 1'b0, 1'b0, 3'd0);
        idle(6);

        // Wrap-around of the fetch PC.
        cycle(1'b0, 1'b1, 12'o7776, 1'b0, 1'b0, 1'b0, 3'd0);
        idle(8);

        // halt together with redirect must not stop fetching.
        cycle(1'b0, 1'b1, 12'o0100, 1'b1, 1'b0, 1'b0, 3'd0);
        idle(5);

        // Halt with one entry queued and one read in flight.
        cycle(1'b1, 1'b0, 12'd0, 1'b1, 1'b0, 1'b0, 3'd0);
        cycle(1'b1, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0, 3'd0);
        idle(6);

        // Reset clears the sticky halt.
        do_reset(1);
        idle(4);

        // Bank writes.
        cycle(1'b0, 1'b0, 12'd0, 1'b0, 1'b1, 1'b0, 3'd5);
        cycle(1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b1, 3'd3);
        idle(3);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0 || (m_halted && $urandom_range(0, 7) == 0)) begin
                do_reset(1);
            end else begin
                cycle(($urandom_range(0, 2) == 0),
                      ($urandom_range(0, 19) == 0),
                      12'($urandom),
                      ($urandom_range(0, 59) == 0),
                      ($urandom_range(0, 9) == 0),
                      ($urandom_range(0, 9) == 0),
                      3'($urandom));
            end
        end
        idle(4);

        @(negedge clock);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
